// File: rtl/ahb_rf_load_master_if.sv
// Load-request handshake, AHB-Lite read bus and register-file write triple for ahb_rf_load_master.
// Handshake: a request transfers on a rising clk when req_valid & req_ready; req_ready is high only while idle.
interface ahb_rf_load_master_if;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_addr;
  logic [4:0]  req_rd;
  logic [2:0]  req_funct3;
  logic        busy;
  logic        err_pulse;
  logic [31:0] HADDR;
  logic [1:0]  HTRANS;
  logic        HWRITE;
  logic [2:0]  HSIZE;
  logic [2:0]  HBURST;
  logic [31:0] HRDATA;
  logic        HREADY;
  logic        HRESP;
  logic        AHB_en_rf;
  logic [4:0]  AHB_address_write_rf;
  logic [31:0] ReadData_AHB_rf;
  logic [2:0]  dbg_state;

  modport master (
    input  req_valid, req_addr, req_rd, req_funct3, HRDATA, HREADY, HRESP,
    output req_ready, busy, err_pulse, HADDR, HTRANS, HWRITE, HSIZE, HBURST,
           AHB_en_rf, AHB_address_write_rf, ReadData_AHB_rf, dbg_state
  );

  modport slave (
    output req_valid, req_addr, req_rd, req_funct3, HRDATA, HREADY, HRESP,
    input  req_ready, busy, err_pulse, HADDR, HTRANS, HWRITE, HSIZE, HBURST,
           AHB_en_rf, AHB_address_write_rf, ReadData_AHB_rf, dbg_state
  );
endinterface

// File: rtl/ahb_rf_load_master.sv
// AHB-Lite single-read load unit: runs one RV32I load per request and writes the
// aligned, extended result into the register file through its AHB write port.
module ahb_rf_load_master #(
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic                 clk,
  input  logic                 rst_n,
  ahb_rf_load_master_if.master bus
);

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_ADDR = 3'd1,
    S_DATA = 3'd2,
    S_WB   = 3'd3,
    S_ERR  = 3'd4
  } state_t;

  state_t      state;
  logic [31:0] addr_q;
  logic [4:0]  rd_q;
  logic [2:0]  f3_q;
  logic [CW-1:0] tmo_cnt;
  logic [31:0] haddr_q;
  logic [1:0]  htrans_q;
  logic [2:0]  hsize_q;
  logic        err_q;
  logic        en_q;
  logic [4:0]  waddr_q;
  logic [31:0] wdata_q;

  logic        f3_legal;
  logic        misaligned;
  logic        tmo_hit;
  logic [7:0]  byte_lane;
  logic [15:0] half_lane;
  logic [31:0] lane_data;

  always_comb begin
    f3_legal = 1'b0;
    case (bus.req_funct3)
      3'b000, 3'b001, 3'b010, 3'b100, 3'b101: f3_legal = 1'b1;
      default:                                f3_legal = 1'b0;
    endcase
  end

  assign misaligned = ((bus.req_funct3[1:0] == 2'b01) && bus.req_addr[0]) ||
                      ((bus.req_funct3[1:0] == 2'b10) && (bus.req_addr[1:0] != 2'b00));

  // Hitting the last allowed stall cycle aborts on this edge, so the abort
  // lands exactly TIMEOUT_CYCLES HREADY-low cycles after the phase began.
  assign tmo_hit = (tmo_cnt == CW'(TIMEOUT_CYCLES - 1));

  always_comb begin
    byte_lane = bus.HRDATA[{addr_q[1:0], 3'b000} +: 8];
    half_lane = bus.HRDATA[{addr_q[1], 4'b0000} +: 16];
    case (f3_q)
      3'b000:  lane_data = {{24{byte_lane[7]}}, byte_lane};
      3'b100:  lane_data = {24'h0, byte_lane};
      3'b001:  lane_data = {{16{half_lane[15]}}, half_lane};
      3'b101:  lane_data = {16'h0, half_lane};
      default: lane_data = bus.HRDATA;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      addr_q   <= '0;
      rd_q     <= '0;
      f3_q     <= '0;
      tmo_cnt  <= '0;
      haddr_q  <= '0;
      htrans_q <= 2'b00;
      hsize_q  <= '0;
      err_q    <= 1'b0;
      en_q     <= 1'b0;
      waddr_q  <= '0;
      wdata_q  <= '0;
    end else begin
      err_q <= 1'b0;
      en_q  <= 1'b0;
      case (state)
        S_IDLE: begin
          if (bus.req_valid) begin
            addr_q  <= bus.req_addr;
            rd_q    <= bus.req_rd;
            f3_q    <= bus.req_funct3;
            tmo_cnt <= '0;
            if (!f3_legal || misaligned) begin
              state <= S_ERR;
              err_q <= 1'b1;
            end else begin
              state    <= S_ADDR;
              htrans_q <= 2'b10;
              haddr_q  <= bus.req_addr;
              hsize_q  <= {1'b0, bus.req_funct3[1:0]};
            end
          end
        end
        S_ADDR: begin
          if (bus.HREADY) begin
            state    <= S_DATA;
            htrans_q <= 2'b00;
            tmo_cnt  <= '0;
          end else if (tmo_hit) begin
            state    <= S_ERR;
            err_q    <= 1'b1;
            htrans_q <= 2'b00;
            tmo_cnt  <= '0;
          end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
          end
        end
        S_DATA: begin
          // An ERROR response is two cycles; only its HREADY-high cycle ends the phase.
          if (bus.HREADY) begin
            tmo_cnt <= '0;
            if (bus.HRESP) begin
              state <= S_ERR;
              err_q <= 1'b1;
            end else begin
              state   <= S_WB;
              en_q    <= (rd_q != 5'd0);
              waddr_q <= rd_q;
              wdata_q <= lane_data;
            end
          end else if (tmo_hit) begin
            state    <= S_ERR;
            err_q    <= 1'b1;
            htrans_q <= 2'b00;
            tmo_cnt  <= '0;
          end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
          end
        end
        S_WB: begin
          state   <= S_IDLE;
          tmo_cnt <= '0;
        end
        S_ERR: begin
          state   <= S_IDLE;
          tmo_cnt <= '0;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.req_ready            = (state == S_IDLE);
  assign bus.busy                 = (state != S_IDLE);
  assign bus.err_pulse            = err_q;
  assign bus.HADDR                = haddr_q;
  assign bus.HTRANS               = htrans_q;
  assign bus.HWRITE               = 1'b0;
  assign bus.HSIZE                = hsize_q;
  assign bus.HBURST               = 3'b000;
  assign bus.AHB_en_rf            = en_q;
  assign bus.AHB_address_write_rf = waddr_q;
  assign bus.ReadData_AHB_rf      = wdata_q;
  assign bus.dbg_state            = state;

endmodule

// File: tb/tb_ahb_rf_load_master.sv
// Bench for ahb_rf_load_master: a driver plays core and AHB slave, a monitor checks every
// RF strobe / err_pulse against expectations queued from a behavioural load model.
module tb_ahb_rf_load_master;

  localparam int TO = 4;
  localparam int W  = 70;  // {err, rd[4:0], data[31:0], cycle[31:0]}

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  ahb_rf_load_master_if bus ();

  ahb_rf_load_master #(.TIMEOUT_CYCLES(TO)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int errors = 0;
  int checks = 0;
  logic [W-1:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h, required 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- reference model ----------------
  // Returns {error, data}: size from funct3, alignment by modulo, lane by shifting,
  // sign extension by subtracting the field's range when its top bit is set.
  function automatic logic [32:0] ref_load(input logic [31:0] addr, input logic [2:0] f3,
                                           input logic [31:0] hr);
    int unsigned size;
    logic [31:0] v;
    if (f3 == 3'd3 || f3 > 3'd5) return {1'b1, 32'h0};
    size = 1 << f3[1:0];
    if ((addr % size) != 0) return {1'b1, 32'h0};
    v = hr >> (8 * (addr % 4));
    if (size == 1) begin
      v = v % 256;
      if (!f3[2] && v >= 128) v = v - 256;
    end else if (size == 2) begin
      v = v % 65536;
      if (!f3[2] && v >= 32768) v = v - 65536;
    end
    return {1'b0, v};
  endfunction

  // ---------------- monitor / scoreboard ----------------
  always @(negedge clk) begin
    logic [W-1:0] e;
    if (rst_n && (bus.AHB_en_rf || bus.err_pulse)) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_event: en=%0d err=%0d rd=%0d data=0x%08h at cycle %0d, required none",
                 bus.AHB_en_rf, bus.err_pulse, bus.AHB_address_write_rf, bus.ReadData_AHB_rf, cyc);
      end else begin
        e = exp_q.pop_front();
        check("evt_kind", {30'h0, bus.err_pulse, bus.AHB_en_rf}, {30'h0, e[69], ~e[69]});
        check("evt_cycle", cyc, e[31:0]);
        if (!e[69]) begin
          check("wb_rd", {27'h0, bus.AHB_address_write_rf}, {27'h0, e[68:64]});
          check("wb_data", bus.ReadData_AHB_rf, e[63:32]);
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic wait_ready(output int at);
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (bus.req_ready) begin
        at = cyc;
        return;
      end
    end
    at = -1;
    checks++;
    errors++;
    $display("FAIL ready_timeout: req_ready still 0 after 50 cycles, required 1");
  endtask

  // mode 0 normal, 1 two-cycle ERROR response, 2 HREADY stuck low in DATA, 3 stuck low in ADDR.
  // Called at a negedge with the unit idle; returns at the negedge where it is idle again.
  task automatic do_load(input logic [31:0] addr, input logic [4:0] rd, input logic [2:0] f3,
                         input logic [31:0] hr, input int aw, input int dw, input int mode,
                         input bit hold);
    logic [32:0] m;
    int acc, ev, idle_at, na, nd;
    m = ref_load(addr, f3, hr);
    bus.req_valid  = 1'b1;
    bus.req_addr   = addr;
    bus.req_rd     = rd;
    bus.req_funct3 = f3;
    @(posedge clk);
    #1;
    acc = cyc;
    if (hold && !m[32]) begin
      // A different request left pending while busy must be ignored.
      bus.req_rd   = ~rd;
      bus.req_addr = addr ^ 32'h4;
    end else begin
      bus.req_valid = 1'b0;
    end

    if (m[32]) begin
      ev = acc;
      exp_q.push_back({1'b1, 5'd0, 32'h0, 32'(ev)});
      @(negedge clk);
      check("illegal_htrans", {30'h0, bus.HTRANS}, 32'h0);
      check("illegal_busy", {31'h0, bus.busy}, 32'h1);
      idle_at = ev + 1;
    end else begin
      case (mode)
        1:       ev = acc + 3 + aw + dw;
        2:       ev = acc + 1 + aw + TO;
        3:       ev = acc + TO;
        default: ev = acc + 2 + aw + dw;
      endcase
      if (mode != 0) exp_q.push_back({1'b1, 5'd0, 32'h0, 32'(ev)});
      else if (rd != 5'd0) exp_q.push_back({1'b0, rd, m[31:0], 32'(ev)});
      idle_at = ev + 1;

      na = (mode == 3) ? TO : aw + 1;
      for (int i = 0; i < na; i++) begin
        bus.HREADY = (mode != 3) && (i == aw);
        bus.HRESP  = 1'b0;
        @(negedge clk);
        check("addr_htrans", {30'h0, bus.HTRANS}, 32'h2);
        check("addr_haddr", bus.HADDR, addr);
        check("addr_hsize", {29'h0, bus.HSIZE}, {30'h0, f3[1:0]});
        check("addr_const", {27'h0, bus.HWRITE, bus.HBURST, bus.req_ready}, 32'h0);
        @(posedge clk);
        #1;
      end

      if (mode == 3) begin
        bus.req_valid = 1'b0;
        bus.HREADY = 1'b1;
        @(negedge clk);
        check("tmo_addr_htrans", {30'h0, bus.HTRANS}, 32'h0);
      end else begin
        case (mode)
          1:       nd = dw + 2;
          2:       nd = TO;
          default: nd = dw + 1;
        endcase
        for (int i = 0; i < nd; i++) begin
          bus.HREADY = (mode != 2) && (i == nd - 1);
          bus.HRESP  = (mode == 1) && (i >= dw);
          bus.HRDATA = (i == nd - 1) ? hr : $urandom();
          @(negedge clk);
          check("data_htrans", {30'h0, bus.HTRANS}, 32'h0);
          check("data_haddr", bus.HADDR, addr);
          check("data_busy", {31'h0, bus.busy}, 32'h1);
          @(posedge clk);
          #1;
        end
        bus.req_valid = 1'b0;
        bus.HREADY = 1'b1;
        bus.HRESP  = 1'b0;
      end
    end

    begin
      int at;
      wait_ready(at);
      check("ready_return", at, idle_at);
    end
  endtask

  task automatic reset_mid_transfer();
    int at;
    bus.req_valid  = 1'b1;
    bus.req_addr   = 32'h200;
    bus.req_rd     = 5'd9;
    bus.req_funct3 = 3'b010;
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    bus.HREADY = 1'b1;
    @(posedge clk);
    #1;
    bus.HREADY = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    check("rst_htrans", {30'h0, bus.HTRANS}, 32'h0);
    check("rst_haddr", bus.HADDR, 32'h0);
    check("rst_flags", {27'h0, bus.busy, bus.err_pulse, bus.AHB_en_rf, bus.HWRITE, bus.req_ready}, 32'h1);
    check("rst_rf", {bus.AHB_address_write_rf, bus.ReadData_AHB_rf[26:0]} | {5'h0, bus.ReadData_AHB_rf[31:27], 22'h0}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    bus.HREADY = 1'b1;
    wait_ready(at);
    check("rst_release_ready", {31'h0, bus.busy}, 32'h0);
    repeat (4) @(negedge clk);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int at;
    bus.req_valid  = 1'b0;
    bus.req_addr   = '0;
    bus.req_rd     = '0;
    bus.req_funct3 = '0;
    bus.HRDATA     = '0;
    bus.HREADY     = 1'b1;
    bus.HRESP      = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_htrans", {30'h0, bus.HTRANS}, 32'h0);
    check("reset_haddr", bus.HADDR, 32'h0);
    check("reset_hsize", {29'h0, bus.HSIZE}, 32'h0);
    check("reset_flags", {27'h0, bus.busy, bus.err_pulse, bus.AHB_en_rf, bus.HWRITE, bus.req_ready}, 32'h1);
    check("reset_rf_addr", {27'h0, bus.AHB_address_write_rf}, 32'h0);
    check("reset_rf_data", bus.ReadData_AHB_rf, 32'h0);
    rst_n = 1'b1;
    wait_ready(at);

    do_load(32'h100, 5'd5,  3'b010, 32'hDEADBEEF, 0, 0, 0, 1'b0);
    do_load(32'h103, 5'd7,  3'b000, 32'h80FF0000, 0, 0, 0, 1'b0);
    do_load(32'h103, 5'd8,  3'b100, 32'h80FF0000, 0, 0, 0, 1'b0);
    do_load(32'h102, 5'd10, 3'b001, 32'h80011234, 0, 0, 0, 1'b0);
    do_load(32'h102, 5'd11, 3'b101, 32'h80011234, 0, 0, 0, 1'b0);
    do_load(32'h100, 5'd5,  3'b010, 32'hCAFEF00D, 0, 3, 0, 1'b0);
    do_load(32'h104, 5'd6,  3'b010, 32'h12345678, 0, 0, 1, 1'b0);
    do_load(32'h101, 5'd3,  3'b001, 32'h0,        0, 0, 0, 1'b0);
    do_load(32'h108, 5'd4,  3'b010, 32'h0,        0, 0, 2, 1'b0);
    do_load(32'h10C, 5'd4,  3'b010, 32'h0,        0, 0, 3, 1'b0);
    do_load(32'h110, 5'd0,  3'b010, 32'h55AA55AA, 0, 0, 0, 1'b0);
    do_load(32'h110, 5'd12, 3'b011, 32'h0,        0, 0, 0, 1'b0);
    do_load(32'h114, 5'd13, 3'b001, 32'h7FFF8000, 2, 1, 0, 1'b1);

    for (int n = 0; n < 60; n++) begin
      logic [31:0] a;
      logic [2:0]  f;
      int r, md;
      a = $urandom();
      f = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 3) != 0) a = a & ~((32'h1 << f[1:0]) - 32'h1);
      r  = $urandom_range(0, 19);
      md = (r < 16) ? 0 : (r < 18) ? 1 : (r == 18) ? 2 : 3;
      do_load(a, 5'($urandom_range(0, 31)), f, $urandom(), $urandom_range(0, 2),
              $urandom_range(0, 2), md, ($urandom_range(0, 3) == 0));
    end

    reset_mid_transfer();

    check("leftover_expect", exp_q.size(), 32'h0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1, "watchdog expired");
  end

endmodule
